// File: rtl/placar_ataque.sv
// Scoreboard stage after the attack manager: BCD shot/hit counters, remaining ship
// cells, win/lose detection and pulse-stretched RGB result LEDs.
module placar_ataque #(
    parameter int MAX_TIROS   = 20,
    parameter int STATUS_HOLD = 381,
    parameter int HOLD_W      = 9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       tiro,
    input  logic       acerto,
    input  logic       repetido,
    input  logic [5:0] navios,
    output logic [3:0] tiros_dez,
    output logic [3:0] tiros_uni,
    output logic [3:0] acertos_dez,
    output logic [3:0] acertos_uni,
    output logic [5:0] restantes,
    output logic [1:0] estado,
    output logic       vitoria,
    output logic       derrota,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        JOGANDO = 2'b01,
        VITORIA = 2'b10,
        DERROTA = 2'b11
    } estado_t;

    localparam logic [3:0]        MAX_DEZ   = 4'(MAX_TIROS / 10);
    localparam logic [3:0]        MAX_UNI   = 4'(MAX_TIROS % 10);
    localparam logic [7:0]        MAX_BCD   = {MAX_DEZ, MAX_UNI};
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(STATUS_HOLD);

    estado_t           state_q, state_d;
    logic [7:0]        tiros_q, tiros_d;
    logic [7:0]        acertos_q, acertos_d;
    logic [5:0]        restantes_q, restantes_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              led_r_q, led_r_d;
    logic              led_g_q, led_g_d;
    logic              led_b_q, led_b_d;
    logic              vitoria_q, vitoria_d;
    logic              derrota_q, derrota_d;

    // Two-digit BCD increment that saturates at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            return v;
        end else if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        tiros_d     = tiros_q;
        acertos_d   = acertos_q;
        restantes_d = restantes_q;
        hold_d      = hold_q;
        led_r_d     = led_r_q;
        led_g_d     = led_g_q;
        led_b_d     = led_b_q;

        if (!enable) begin
            state_d     = OCIOSO;
            tiros_d     = 8'h00;
            acertos_d   = 8'h00;
            restantes_d = 6'd0;
            hold_d      = '0;
            led_r_d     = 1'b0;
            led_g_d     = 1'b0;
            led_b_d     = 1'b0;
        end else begin
            case (state_q)
                OCIOSO: begin
                    tiros_d     = 8'h00;
                    acertos_d   = 8'h00;
                    restantes_d = navios;
                    hold_d      = '0;
                    led_r_d     = 1'b0;
                    led_b_d     = 1'b0;
                    if (navios == 6'd0) begin
                        state_d = VITORIA;
                        led_g_d = 1'b1;
                    end else begin
                        state_d = JOGANDO;
                        led_g_d = 1'b0;
                    end
                end

                JOGANDO: begin
                    if (tiro) begin
                        hold_d  = HOLD_INIT;
                        led_b_d = repetido;
                        led_g_d = !repetido && acerto;
                        led_r_d = !repetido && !acerto;
                        if (!repetido) begin
                            tiros_d = bcd_inc(tiros_q);
                            if (acerto) begin
                                acertos_d = bcd_inc(acertos_q);
                                if (restantes_q != 6'd0) begin
                                    restantes_d = restantes_q - 6'd1;
                                end
                            end
                        end
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) begin
                            led_r_d = 1'b0;
                            led_g_d = 1'b0;
                            led_b_d = 1'b0;
                        end
                    end

                    // Victory is tested first so a sinking hit on the last allowed shot wins.
                    if (restantes_d == 6'd0) begin
                        state_d = VITORIA;
                        hold_d  = '0;
                        led_r_d = 1'b0;
                        led_g_d = 1'b1;
                        led_b_d = 1'b0;
                    end else if (tiros_d == MAX_BCD) begin
                        state_d = DERROTA;
                        hold_d  = '0;
                        led_r_d = 1'b1;
                        led_g_d = 1'b0;
                        led_b_d = 1'b0;
                    end
                end

                VITORIA, DERROTA: begin
                end
            endcase
        end

        vitoria_d = (state_d == VITORIA);
        derrota_d = (state_d == DERROTA);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= OCIOSO;
            tiros_q     <= 8'h00;
            acertos_q   <= 8'h00;
            restantes_q <= 6'd0;
            hold_q      <= '0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            led_b_q     <= 1'b0;
            vitoria_q   <= 1'b0;
            derrota_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tiros_q     <= tiros_d;
            acertos_q   <= acertos_d;
            restantes_q <= restantes_d;
            hold_q      <= hold_d;
            led_r_q     <= led_r_d;
            led_g_q     <= led_g_d;
            led_b_q     <= led_b_d;
            vitoria_q   <= vitoria_d;
            derrota_q   <= derrota_d;
        end
    end

    assign tiros_dez   = tiros_q[7:4];
    assign tiros_uni   = tiros_q[3:0];
    assign acertos_dez = acertos_q[7:4];
    assign acertos_uni = acertos_q[3:0];
    assign restantes   = restantes_q;
    assign estado      = state_q;
    assign vitoria     = vitoria_q;
    assign derrota     = derrota_q;
    assign led_r       = led_r_q;
    assign led_g       = led_g_q;
    assign led_b       = led_b_q;

endmodule
